// File: rtl/uart_pkg.sv
// Shared UART definitions: bit timing default, 8N1 frame constants and the receiver state encoding.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 10416;
  localparam int CNT_W            = 14;

  localparam int   DATA_BITS = 8;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_BREAK = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = RX_IDLE,
    S_START = RX_START,
    S_DATA  = RX_DATA,
    S_STOP  = RX_STOP,
    S_BREAK = RX_BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line in, received byte plus status strobes out.
interface uart_rx_if;

  logic       rx;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  // Line driver / byte consumer side.
  modport master (
    output rx,
    input  data_out,
    input  data_valid,
    input  frame_err,
    input  busy
  );

  // Receiver side.
  modport slave (
    input  rx,
    output data_out,
    output data_valid,
    output frame_err,
    output busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; resets to RST_VAL.
module sync_2ff #(
  parameter bit RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start validated at mid-bit, data sampled at bit centres, stop checked,
// and a held-low line parked in BREAK so it is never read as repeated 0x00 frames.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_rx_if.slave rx_bus
);

  localparam int               HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  sync_2ff #(.RST_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_bus.rx),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Every shift-register bit is rewritten before it is read, so it needs no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_s == START_BIT) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (rx_s == START_BIT) ? S_DATA : S_IDLE;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == LAST_BIT) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s == STOP_BIT) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_d = '0;
        if (rx_s == STOP_BIT) state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign rx_bus.data_out   = data_q;
  assign rx_bus.data_valid = valid_q;
  assign rx_bus.frame_err  = ferr_q;
  assign rx_bus.busy       = (state_q != S_IDLE);

endmodule
